// File: rtl/vector_sequencer.sv
// vector_sequencer: start/done sequencer that drives all 8 input vectors into `simple` and captures its responses.
// Define VECTOR_SEQUENCER_GRAY_EN for Gray-coded stimulus order instead of binary.
module vector_sequencer #(
  parameter int SETTLE = 100,
  parameter int DWELL = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        out_1,
  input  logic        out_2,
  output logic        in_1,
  output logic        in_2,
  output logic        in_3,
  output logic [2:0]  vec_idx,
  output logic        busy,
  output logic        done,
  output logic [15:0] results
);
  localparam logic [1:0] S_IDLE = 2'd0, S_SETTLE = 2'd1, S_DRIVE = 2'd2, S_DONE = 2'd3;
  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE - 1);
  localparam logic [15:0] DWELL_LAST = 16'(DWELL - 1);
  logic [1:0] state;
  logic [15:0] cnt;
  logic [2:0] stim, nxt_idx, nxt_pat;
  assign {in_1, in_2, in_3} = stim;
  assign nxt_idx = vec_idx + 3'd1;
`ifdef VECTOR_SEQUENCER_GRAY_EN
  assign nxt_pat = nxt_idx ^ (nxt_idx >> 1);
`else
  assign nxt_pat = nxt_idx;
`endif
  // pattern(0) is 000 in both orders, so SETTLE->DRIVE needs no stimulus change
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      stim    <= '0;
      vec_idx <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      results <= '0;
    end else if ((state == S_IDLE || state == S_DONE) && start) begin
      state   <= S_SETTLE;
      cnt     <= '0;
      stim    <= '0;
      vec_idx <= '0;
      busy    <= 1'b1;
      done    <= 1'b0;
      results <= '0;
    end else if (state == S_SETTLE) begin
      cnt <= cnt + 16'd1;
      if (cnt == SETTLE_LAST) begin
        state <= S_DRIVE;
        cnt   <= '0;
      end
    end else if (state == S_DRIVE) begin
      cnt <= cnt + 16'd1;
      if (cnt == DWELL_LAST) begin
        results[{vec_idx, 1'b0} +: 2] <= {out_1, out_2};
        cnt <= '0;
        if (vec_idx == 3'd7) begin
          state <= S_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end else begin
          vec_idx <= nxt_idx;
          stim    <= nxt_pat;
        end
      end
    end
  end
endmodule
